// File: rtl/cadr_pkg.sv
// Shared types and constants for the CADR run-control sequencer.
package cadr_pkg;

    typedef enum logic [1:0] {
        StRstHold  = 2'd0,
        StHalted   = 2'd1,
        StRunning  = 2'd2,
        StStepping = 2'd3
    } run_state_e;

    localparam logic [1:0] CMD_HALT  = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_STEP  = 2'd2;
    localparam logic [1:0] CMD_RESET = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_CMD  = 2'd1;
    localparam logic [1:0] CAUSE_CPU  = 2'd2;
    localparam logic [1:0] CAUSE_STEP = 2'd3;

endpackage

// File: rtl/cadr_run_hold.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module cadr_run_hold #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned INIT  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !done) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= WIDTH'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/cadr_run_ctl.sv
// Run-control sequencer for the CADR core: reset hold, run, halt and single-step,
// with per-cycle enable gating and a retired-cycle counter.
module cadr_run_ctl
    import cadr_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 16,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned CYC_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_count,
    input  logic              cpu_wait,
    input  logic              cpu_halt,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              cmd_err,
    output logic [STEP_W-1:0] steps_left,
    output logic [CYC_W-1:0]  cyc_count
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    run_state_e        state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              err_q, err_d;
    logic              hold_load, hold_en, hold_done;
    logic              accept, active;

    cadr_run_hold #(
        .WIDTH (HOLD_W),
        .INIT  (RESET_HOLD - 1)
    ) u_hold (
        .clock    (clock),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_W'(RESET_HOLD - 1)),
        .en       (hold_en),
        .done     (hold_done)
    );

    assign cmd_ready = (state_q != StRstHold);
    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state_q == StRunning) || (state_q == StStepping);
    assign cpu_run   = active && !cpu_wait && !cpu_halt;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        steps_d   = steps_q;
        cyc_d     = cpu_run ? cyc_q + CYC_W'(1) : cyc_q;
        hold_load = 1'b0;
        hold_en   = 1'b0;
        // Illegal commands are flagged even if something else moves the state this cycle.
        err_d     = accept && (((cmd_op == CMD_RUN) && (state_q == StStepping)) ||
                               ((cmd_op == CMD_STEP) && (state_q != StHalted)));

        case (state_q)
            StRstHold: begin
                hold_en = 1'b1;
                if (hold_done) state_d = StHalted;
            end
            StHalted: begin
                if (accept) begin
                    case (cmd_op)
                        CMD_RUN: begin
                            state_d = StRunning;
                            cause_d = CAUSE_NONE;
                        end
                        CMD_STEP: begin
                            state_d = StStepping;
                            cause_d = CAUSE_NONE;
                            steps_d = (cmd_count == '0) ? STEP_W'(1) : cmd_count;
                        end
                        default: ;
                    endcase
                end
            end
            StRunning: begin
                if (cpu_halt) begin
                    state_d = StHalted;
                    cause_d = CAUSE_CPU;
                end else if (accept && (cmd_op == CMD_HALT)) begin
                    state_d = StHalted;
                    cause_d = CAUSE_CMD;
                end
            end
            StStepping: begin
                if (cpu_halt) begin
                    state_d = StHalted;
                    cause_d = CAUSE_CPU;
                    steps_d = '0;
                end else if (accept && (cmd_op == CMD_HALT)) begin
                    state_d = StHalted;
                    cause_d = CAUSE_CMD;
                    steps_d = '0;
                end else if (cpu_run) begin
                    if (steps_q == STEP_W'(1)) begin
                        state_d = StHalted;
                        cause_d = CAUSE_STEP;
                        steps_d = '0;
                    end else begin
                        steps_d = steps_q - STEP_W'(1);
                    end
                end
            end
            default: state_d = StRstHold;
        endcase

        // RESET outranks every other event in the cycle.
        if (accept && (cmd_op == CMD_RESET)) begin
            state_d   = StRstHold;
            hold_load = 1'b1;
            cyc_d     = '0;
            steps_d   = '0;
            cause_d   = CAUSE_NONE;
        end

        cpu_reset_d = (state_d == StRstHold);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StRstHold;
            cause_q     <= CAUSE_NONE;
            steps_q     <= '0;
            cyc_q       <= '0;
            cpu_reset_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            steps_q     <= steps_d;
            cyc_q       <= cyc_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign halted     = (state_q == StHalted);
    assign halt_cause = cause_q;
    assign cmd_err    = err_q;
    assign steps_left = steps_q;
    assign cyc_count  = cyc_q;

endmodule

// File: tb/tb_cadr_run_ctl.sv
// Scoreboard bench for cadr_run_ctl: stimulus queues expected snapshots, a negedge
// monitor pops and compares them and counts cpu_run / cpu_reset cycles in between.
module tb_cadr_run_ctl;
    import cadr_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_count = 16'd0;
    logic        cpu_wait = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_reset, cpu_run, halted, cmd_err;
    logic [1:0]  halt_cause;
    logic [15:0] steps_left;
    logic [31:0] cyc_count;

    cadr_run_ctl #(
        .RESET_HOLD (16),
        .STEP_W     (16),
        .CYC_W      (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cpu_wait   (cpu_wait),
        .cpu_halt   (cpu_halt),
        .cpu_reset  (cpu_reset),
        .cpu_run    (cpu_run),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cmd_err    (cmd_err),
        .steps_left (steps_left),
        .cyc_count  (cyc_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        rdy;
        logic        hlt;
        logic        run;
        logic        err;
        logic [1:0]  cause;
        logic [15:0] steps;
        logic [31:0] cyc;
        int          runs;
        int          rsts;
    } exp_t;

    exp_t sb[$];
    logic chk_req = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   run_cnt = 0;
    int   rst_cnt = 0;

    task automatic cmp(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: sample each negedge, compare when a check is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (cpu_run === 1'b1) run_cnt++;
            if (cpu_reset === 1'b1) rst_cnt++;
            if (chk_req) begin
                chk_req = 1'b0;
                if (sb.size() == 0) begin
                    cmp("monitor", "queue_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    cmp(e.name, "cpu_reset", 64'(cpu_reset), 64'(e.rst));
                    cmp(e.name, "cmd_ready", 64'(cmd_ready), 64'(e.rdy));
                    cmp(e.name, "halted", 64'(halted), 64'(e.hlt));
                    cmp(e.name, "cpu_run", 64'(cpu_run), 64'(e.run));
                    cmp(e.name, "cmd_err", 64'(cmd_err), 64'(e.err));
                    cmp(e.name, "halt_cause", 64'(halt_cause), 64'(e.cause));
                    cmp(e.name, "steps_left", 64'(steps_left), 64'(e.steps));
                    cmp(e.name, "cyc_count", 64'(cyc_count), 64'(e.cyc));
                    cmp(e.name, "run_pulses", 64'(run_cnt), 64'(e.runs));
                    cmp(e.name, "reset_cycles", 64'(rst_cnt), 64'(e.rsts));
                end
                run_cnt = 0;
                rst_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Queue a snapshot for the coming negedge; counts cover negedges since the last check.
    task automatic expect_state(input string nm, input logic rst, input logic rdy,
                                input logic hlt, input logic run, input logic err,
                                input logic [1:0] cause, input int steps, input int cyc,
                                input int runs, input int rsts);
        exp_t e;
        e.name  = nm;
        e.rst   = rst;
        e.rdy   = rdy;
        e.hlt   = hlt;
        e.run   = run;
        e.err   = err;
        e.cause = cause;
        e.steps = 16'(steps);
        e.cyc   = 32'(cyc);
        e.runs  = runs;
        e.rsts  = rsts;
        sb.push_back(e);
        chk_req = 1'b1;
        @(negedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                         rst rdy hlt run err cause steps cyc runs rsts
        step();
        expect_state("por",          1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
        step();
        reset = 1'b1;
        repeat (16) step();
        expect_state("hold_release", 0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 16);

        issue(CMD_STEP, 16'd3);
        expect_state("step3_start",  0, 1, 0, 1, 0, 2'd0, 3, 0, 1, 0);
        step();
        cpu_wait = 1'b1;
        step();
        cpu_wait = 1'b0;
        step();
        step();
        expect_state("step3_done",   0, 1, 1, 0, 0, 2'd3, 0, 3, 2, 0);

        issue(CMD_STEP, 16'd0);
        step();
        expect_state("step0_done",   0, 1, 1, 0, 0, 2'd3, 0, 4, 1, 0);

        issue(CMD_RUN, 16'd0);
        issue(CMD_STEP, 16'd5);
        expect_state("step_in_run",  0, 1, 0, 1, 1, 2'd0, 0, 5, 2, 0);
        step();
        expect_state("err_pulse",    0, 1, 0, 1, 0, 2'd0, 0, 6, 1, 0);

        cpu_halt  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = CMD_HALT;
        step();
        cpu_halt  = 1'b0;
        cmd_valid = 1'b0;
        expect_state("halt_both",    0, 1, 1, 0, 0, 2'd2, 0, 6, 0, 0);

        issue(CMD_RUN, 16'd0);
        issue(CMD_HALT, 16'd0);
        expect_state("halt_cmd",     0, 1, 1, 0, 0, 2'd1, 0, 7, 1, 0);

        issue(CMD_RUN, 16'd0);
        expect_state("run_clears",   0, 1, 0, 1, 0, 2'd0, 0, 7, 1, 0);
        issue(CMD_RESET, 16'd0);
        repeat (15) step();
        expect_state("reset_hold",   1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 16);
        step();
        expect_state("reset_done",   0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0);

        issue(CMD_RUN, 16'd0);
        repeat (100) step();
        cpu_halt = 1'b1;
        expect_state("halt_gate",    0, 1, 0, 0, 0, 2'd0, 0, 100, 100, 0);
        step();
        cpu_halt = 1'b0;
        expect_state("cpu_halted",   0, 1, 1, 0, 0, 2'd2, 0, 100, 0, 0);

        issue(CMD_STEP, 16'd10);
        step();
        expect_state("step10_mid",   0, 1, 0, 1, 0, 2'd0, 9, 101, 2, 0);
        issue(CMD_RUN, 16'd0);
        expect_state("run_in_step",  0, 1, 0, 1, 1, 2'd0, 8, 102, 1, 0);
        step();
        reset = 1'b0;
        expect_state("async_reset",  1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
        reset = 1'b1;
        step();

        cmp("end", "queue_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
